when_suite_dispatch_2: RTL and testbench

- Two-way token dispatcher: the splitting counterpart to the two-input priority merge blocks in the When test family.
- Accepts one valid/ready input stream; each token carries a destination code that routes it to output 0, output 1, both, or nowhere.
- Each output is buffered by a small registered queue; per-path accept counters support bench checking.
- Sits downstream of a merge stage, so merge and dispatch can be tested back-to-back.

---
 rtl/when_suite_pkg.sv | 15 +
 rtl/when_suite_queue.sv | 58 +++++
 rtl/when_suite_dispatch_2.sv | 89 ++++++++
 tb/tb_when_suite_dispatch_2.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/when_suite_pkg.sv
// Shared definitions for the When-suite dispatcher: destination codes and default sizes.
package when_suite_pkg;

  localparam int unsigned W_DEF     = 8;
  localparam int unsigned DEPTH_DEF = 2;
  localparam int unsigned CW_DEF    = 8;

  typedef enum logic [1:0] {
    DEST_DROP  = 2'b00,
    DEST_OUT0  = 2'b01,
    DEST_OUT1  = 2'b10,
    DEST_BCAST = 2'b11
  } dest_e;

endpackage

// File: rtl/when_suite_queue.sv
// Small circular-buffer queue with registered storage; head is visible whenever non-empty.
module when_suite_queue #(
  parameter int unsigned W     = 8,
  parameter int unsigned DEPTH = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         enq_valid,
  input  logic [W-1:0] enq_bits,
  input  logic         deq_ready,
  output logic         full,
  output logic         deq_valid,
  output logic [W-1:0] deq_bits
);

  localparam int unsigned PW   = $clog2(DEPTH);
  localparam int unsigned CNTW = PW + 1;

  logic [W-1:0]    mem [DEPTH];
  logic [PW-1:0]   rd_ptr;
  logic [PW-1:0]   wr_ptr;
  logic [CNTW-1:0] count;
  logic            do_enq;
  logic            do_deq;

  // Full blocks enqueue even when a dequeue happens in the same cycle.
  assign full      = (count == CNTW'(DEPTH));
  assign deq_valid = (count != '0);
  assign do_enq    = enq_valid && !full;
  assign do_deq    = deq_valid && deq_ready;
  assign deq_bits  = mem[rd_ptr];

  // Storage, pointers and occupancy; DEPTH is a power of two so pointers wrap naturally.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_enq) begin
        mem[wr_ptr] <= enq_bits;
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (do_deq) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      case ({do_enq, do_deq})
        2'b10:   count <= count + CNTW'(1);
        2'b01:   count <= count - CNTW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/when_suite_dispatch_2.sv
// Two-way token dispatcher: routes each accepted token to out0, out1, both or nowhere.
module when_suite_dispatch_2
  import when_suite_pkg::*;
#(
  parameter int unsigned W     = W_DEF,
  parameter int unsigned DEPTH = DEPTH_DEF,
  parameter int unsigned CW    = CW_DEF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          io_in_valid,
  output logic          io_in_ready,
  input  logic [W-1:0]  io_in_bits,
  input  logic [1:0]    io_in_dest,
  output logic          io_out0_valid,
  input  logic          io_out0_ready,
  output logic [W-1:0]  io_out0_bits,
  output logic          io_out1_valid,
  input  logic          io_out1_ready,
  output logic [W-1:0]  io_out1_bits,
  output logic [CW-1:0] io_cnt0,
  output logic [CW-1:0] io_cnt1,
  output logic [CW-1:0] io_cntDrop
);

  dest_e dest;
  logic  full0;
  logic  full1;
  logic  accept;
  logic  enq0;
  logic  enq1;
  logic  drop;

  assign dest = dest_e'(io_in_dest);

  // Ready depends only on the destination and the fullness of the queues it targets.
  always_comb begin
    io_in_ready = 1'b0;
    unique case (dest)
      DEST_DROP:  io_in_ready = 1'b1;
      DEST_OUT0:  io_in_ready = !full0;
      DEST_OUT1:  io_in_ready = !full1;
      DEST_BCAST: io_in_ready = !full0 && !full1;
      default:    io_in_ready = 1'b0;
    endcase
  end

  // A broadcast is only accepted when both queues have room, so both enqueues land together.
  assign accept = io_in_valid && io_in_ready;
  assign enq0   = accept && (dest == DEST_OUT0 || dest == DEST_BCAST);
  assign enq1   = accept && (dest == DEST_OUT1 || dest == DEST_BCAST);
  assign drop   = accept && (dest == DEST_DROP);

  when_suite_queue #(.W(W), .DEPTH(DEPTH)) u_q0 (
    .clk       (clk),
    .reset     (reset),
    .enq_valid (enq0),
    .enq_bits  (io_in_bits),
    .deq_ready (io_out0_ready),
    .full      (full0),
    .deq_valid (io_out0_valid),
    .deq_bits  (io_out0_bits)
  );

  when_suite_queue #(.W(W), .DEPTH(DEPTH)) u_q1 (
    .clk       (clk),
    .reset     (reset),
    .enq_valid (enq1),
    .enq_bits  (io_in_bits),
    .deq_ready (io_out1_ready),
    .full      (full1),
    .deq_valid (io_out1_valid),
    .deq_bits  (io_out1_bits)
  );

  // Per-path statistics counters; wrap silently.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      io_cnt0    <= '0;
      io_cnt1    <= '0;
      io_cntDrop <= '0;
    end else begin
      if (enq0) io_cnt0    <= io_cnt0 + CW'(1);
      if (enq1) io_cnt1    <= io_cnt1 + CW'(1);
      if (drop) io_cntDrop <= io_cntDrop + CW'(1);
    end
  end

endmodule

// File: tb/tb_when_suite_dispatch_2.sv
// Randomised and directed bench for when_suite_dispatch_2 against a queue-based reference model.
module tb_when_suite_dispatch_2;

  localparam int DEPTH = 2;

  logic       clk;
  logic       reset;
  logic       io_in_valid;
  logic       io_in_ready;
  logic [7:0] io_in_bits;
  logic [1:0] io_in_dest;
  logic       io_out0_valid;
  logic       io_out0_ready;
  logic [7:0] io_out0_bits;
  logic       io_out1_valid;
  logic       io_out1_ready;
  logic [7:0] io_out1_bits;
  logic [7:0] io_cnt0;
  logic [7:0] io_cnt1;
  logic [7:0] io_cntDrop;

  int checks = 0;
  int errors = 0;

  // Reference model: two FIFOs of tokens plus plain integer counters.
  logic [7:0] m0[$];
  logic [7:0] m1[$];
  int mc0 = 0;
  int mc1 = 0;
  int mcd = 0;

  when_suite_dispatch_2 dut (
    .clk           (clk),
    .reset         (reset),
    .io_in_valid   (io_in_valid),
    .io_in_ready   (io_in_ready),
    .io_in_bits    (io_in_bits),
    .io_in_dest    (io_in_dest),
    .io_out0_valid (io_out0_valid),
    .io_out0_ready (io_out0_ready),
    .io_out0_bits  (io_out0_bits),
    .io_out1_valid (io_out1_valid),
    .io_out1_ready (io_out1_ready),
    .io_out1_bits  (io_out1_bits),
    .io_cnt0       (io_cnt0),
    .io_cnt1       (io_cnt1),
    .io_cntDrop    (io_cntDrop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic v, input logic [7:0] b, input logic [1:0] d,
                       input logic r0, input logic r1);
    io_in_valid   = v;
    io_in_bits    = b;
    io_in_dest    = d;
    io_out0_ready = r0;
    io_out1_ready = r1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Compare process: check the DUT against the model mid-cycle, then advance the model over the coming edge.
  always @(negedge clk) begin
    if (reset) begin
      m0.delete();
      m1.delete();
      mc0 = 0;
      mc1 = 0;
      mcd = 0;
      chk("rst_out0_valid", 32'(io_out0_valid), 32'd0);
      chk("rst_out1_valid", 32'(io_out1_valid), 32'd0);
      chk("rst_cnt0", 32'(io_cnt0), 32'd0);
      chk("rst_cnt1", 32'(io_cnt1), 32'd0);
      chk("rst_cntDrop", 32'(io_cntDrop), 32'd0);
    end else begin
      bit f0, f1, rdy, acc, go0, go1;
      f0 = (m0.size() >= DEPTH);
      f1 = (m1.size() >= DEPTH);
      case (io_in_dest)
        2'b00:   rdy = 1'b1;
        2'b01:   rdy = !f0;
        2'b10:   rdy = !f1;
        default: rdy = !f0 && !f1;
      endcase
      chk("in_ready", 32'(io_in_ready), 32'(rdy));
      chk("out0_valid", 32'(io_out0_valid), 32'(m0.size() != 0));
      chk("out1_valid", 32'(io_out1_valid), 32'(m1.size() != 0));
      if (m0.size() != 0) chk("out0_bits", 32'(io_out0_bits), 32'(m0[0]));
      if (m1.size() != 0) chk("out1_bits", 32'(io_out1_bits), 32'(m1[0]));
      chk("cnt0", 32'(io_cnt0), 32'(mc0));
      chk("cnt1", 32'(io_cnt1), 32'(mc1));
      chk("cntDrop", 32'(io_cntDrop), 32'(mcd));

      acc = io_in_valid && rdy;
      go0 = (m0.size() != 0) && io_out0_ready;
      go1 = (m1.size() != 0) && io_out1_ready;
      if (go0) void'(m0.pop_front());
      if (go1) void'(m1.pop_front());
      if (acc) begin
        if (io_in_dest[0]) begin m0.push_back(io_in_bits); mc0 = (mc0 + 1) % 256; end
        if (io_in_dest[1]) begin m1.push_back(io_in_bits); mc1 = (mc1 + 1) % 256; end
        if (io_in_dest == 2'b00) mcd = (mcd + 1) % 256;
      end
    end
  end

  initial begin
    reset = 1'b1;
    drive(1'b0, 8'h00, 2'b00, 1'b0, 1'b0);
    #1;
    chk("reset_out0_valid", 32'(io_out0_valid), 32'd0);
    chk("reset_out0_bits", 32'(io_out0_bits), 32'd0);
    chk("reset_out1_bits", 32'(io_out1_bits), 32'd0);
    chk("reset_in_ready", 32'(io_in_ready), 32'd1);
    tick();
    tick();
    reset = 1'b0;

    // Single token to out0.
    drive(1'b1, 8'h5A, 2'b01, 1'b1, 1'b0);
    #1;
    chk("t1_in_ready", 32'(io_in_ready), 32'd1);
    tick();
    drive(1'b0, 8'h00, 2'b00, 1'b1, 1'b0);
    chk("t1_out0_valid", 32'(io_out0_valid), 32'd1);
    chk("t1_out0_bits", 32'(io_out0_bits), 32'h5A);
    chk("t1_out1_valid", 32'(io_out1_valid), 32'd0);
    chk("t1_cnt0", 32'(io_cnt0), 32'd1);
    tick();

    // Broadcast blocked by a full queue 1.
    drive(1'b1, 8'h11, 2'b10, 1'b1, 1'b0); tick();
    drive(1'b1, 8'h22, 2'b10, 1'b1, 1'b0); tick();
    drive(1'b1, 8'h33, 2'b11, 1'b1, 1'b0);
    #1;
    chk("t2_bcast_blocked", 32'(io_in_ready), 32'd0);
    tick();
    chk("t2_q0_untouched", 32'(io_out0_valid), 32'd0);
    io_out1_ready = 1'b1;
    tick();
    io_out1_ready = 1'b0;
    #1;
    chk("t2_bcast_ready", 32'(io_in_ready), 32'd1);
    io_out0_ready = 1'b0;
    tick();
    io_in_valid = 1'b0;
    chk("t2_out0_bits", 32'(io_out0_bits), 32'h33);
    chk("t2_out1_head", 32'(io_out1_bits), 32'h22);
    chk("t2_cnt0", 32'(io_cnt0), 32'd2);
    chk("t2_cnt1", 32'(io_cnt1), 32'd3);
    drive(1'b0, 8'h00, 2'b00, 1'b1, 1'b1);
    repeat (3) tick();

    // Fill queue 0, then drain across the pointer wrap.
    drive(1'b1, 8'h01, 2'b01, 1'b0, 1'b1); tick();
    drive(1'b1, 8'h02, 2'b01, 1'b0, 1'b1); tick();
    drive(1'b1, 8'h03, 2'b01, 1'b0, 1'b1);
    #1;
    chk("t3_full_ready", 32'(io_in_ready), 32'd0);
    io_out0_ready = 1'b1;
    #1;
    chk("t3_full_ready_deq", 32'(io_in_ready), 32'd0);
    chk("t3_head1", 32'(io_out0_bits), 32'h01);
    tick();
    chk("t3_recover", 32'(io_in_ready), 32'd1);
    chk("t3_head2", 32'(io_out0_bits), 32'h02);
    tick();
    io_in_valid = 1'b0;
    chk("t3_head3", 32'(io_out0_bits), 32'h03);
    tick();
    chk("t3_empty", 32'(io_out0_valid), 32'd0);

    // 300 dropped tokens.
    for (int i = 0; i < 300; i++) begin
      drive(1'b1, 8'(i), 2'b00, 1'b0, 1'b0);
      tick();
    end
    io_in_valid = 1'b0;
    chk("t4_cntDrop", 32'(io_cntDrop), 32'd44);
    chk("t4_out0_idle", 32'(io_out0_valid), 32'd0);
    chk("t4_out1_idle", 32'(io_out1_valid), 32'd0);

    // Async reset with both queues full.
    drive(1'b1, 8'hC1, 2'b11, 1'b0, 1'b0); tick();
    drive(1'b1, 8'hC2, 2'b11, 1'b0, 1'b0); tick();
    io_in_valid = 1'b0;
    chk("t5_pre_out0_valid", 32'(io_out0_valid), 32'd1);
    #1;
    reset = 1'b1;
    #1;
    chk("t5_async_out0_valid", 32'(io_out0_valid), 32'd0);
    chk("t5_async_out1_valid", 32'(io_out1_valid), 32'd0);
    chk("t5_async_cnt0", 32'(io_cnt0), 32'd0);
    chk("t5_async_cntDrop", 32'(io_cntDrop), 32'd0);
    tick();
    reset = 1'b0;
    drive(1'b1, 8'hA5, 2'b10, 1'b0, 1'b0);
    tick();
    io_in_valid = 1'b0;
    chk("t5_out1_valid", 32'(io_out1_valid), 32'd1);
    chk("t5_out1_bits", 32'(io_out1_bits), 32'hA5);
    chk("t5_out0_valid", 32'(io_out0_valid), 32'd0);
    io_out1_ready = 1'b1;
    tick();
    chk("t5_only_token", 32'(io_out1_valid), 32'd0);

    // Streaming through queue 0 at occupancy 1.
    drive(1'b1, 8'h40, 2'b01, 1'b0, 1'b0);
    tick();
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 8'(8'h41 + i), 2'b01, 1'b1, 1'b0);
      #1;
      chk("t6_valid", 32'(io_out0_valid), 32'd1);
      chk("t6_head", 32'(io_out0_bits), 32'(8'h40 + i));
      chk("t6_ready", 32'(io_in_ready), 32'd1);
      tick();
    end
    io_in_valid = 1'b0;
    chk("t6_last", 32'(io_out0_bits), 32'h4A);
    tick();
    chk("t6_drained", 32'(io_out0_valid), 32'd0);

    // Random traffic checked by the model.
    for (int i = 0; i < 3000; i++) begin
      drive(1'($urandom_range(0, 3) != 0), 8'($urandom), 2'($urandom),
            1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 2) != 0));
      tick();
    end
    drive(1'b0, 8'h00, 2'b00, 1'b1, 1'b1);
    repeat (4) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
